// File: rtl/chain_mix_pkg.sv
// ============================================================================
// Module  : chain_mix_pkg
// Brief   : Shared types, lane geometry, IV and rotate amounts for chain_mix.
// Revision: 1.0
// ============================================================================
`default_nettype none

package chain_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int LANE_W  = 64;
    localparam int BLOCK_W = 4 * LANE_W;
    localparam int RC_W    = 6;
    localparam int ROT_D   = 32;
    localparam int ROT_B   = 24;

    localparam logic [BLOCK_W-1:0] CHAIN_IV = {4{64'h0412_6424_0034_3C28}};

    function automatic logic [LANE_W-1:0] rotl64(input logic [LANE_W-1:0] x,
                                                 input int unsigned n);
        return (x << n) | (x >> (LANE_W - n));
    endfunction

endpackage

`default_nettype wire

// File: rtl/chain_mix_round.sv
// ============================================================================
// Module  : chain_mix_round
// Brief   : One combinational ARX mixing round over four 64-bit lanes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module chain_mix_round
    import chain_mix_pkg::*;
(
    input  logic [BLOCK_W-1:0] w_in,
    input  logic [RC_W-1:0]    rc,
    output logic [BLOCK_W-1:0] w_out
);

    logic [LANE_W-1:0] a_in, b_in, c_in, d_in;
    logic [LANE_W-1:0] a_nx, b_nx, c_nx, d_nx;

    always_comb begin
        a_in = w_in[4*LANE_W-1:3*LANE_W];
        b_in = w_in[3*LANE_W-1:2*LANE_W];
        c_in = w_in[2*LANE_W-1:LANE_W];
        d_in = w_in[LANE_W-1:0];

        // Each step consumes the lane just updated by the previous one.
        a_nx = a_in + b_in + {{(LANE_W-RC_W){1'b0}}, rc};
        d_nx = rotl64(d_in ^ a_nx, ROT_D);
        c_nx = c_in + d_nx;
        b_nx = rotl64(b_in ^ c_nx, ROT_B);

        w_out = {a_nx, b_nx, c_nx, d_nx};
    end

endmodule

`default_nettype wire

// File: rtl/chain_mix_engine.sv
// ============================================================================
// Module  : chain_mix_engine
// Brief   : Chained ARX block mixer; optional block counter via CHAIN_MIX_BLKCNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module chain_mix_engine
    import chain_mix_pkg::*;
#(
    parameter int ROUNDS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    input  logic [BLOCK_W-1:0] st_q,
    output logic [BLOCK_W-1:0] st_d,
    output logic               st_en,
`ifdef CHAIN_MIX_BLKCNT_EN
    output logic [31:0]        blk_count,
`endif
    output logic               st_clear
);

    localparam logic [RC_W-1:0] ROUND_LAST = RC_W'(ROUNDS - 1);

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] w_q, w_d;
    logic [BLOCK_W-1:0] chain_q, chain_d;
    logic [RC_W-1:0]    rnd_q, rnd_d;
    logic [BLOCK_W-1:0] w_round;
    logic [BLOCK_W-1:0] w_final;

    chain_mix_round u_round (
        .w_in  (w_q),
        .rc    (rnd_q),
        .w_out (w_round)
    );

    assign w_final = w_q ^ chain_q;

`ifdef CHAIN_MIX_BLKCNT_EN
    logic [31:0] blk_q, blk_d;
    assign blk_count = blk_q;
`endif

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        chain_d   = chain_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        st_en     = 1'b0;
        st_clear  = 1'b0;
        st_d      = '0;
`ifdef CHAIN_MIX_BLKCNT_EN
        blk_d     = blk_q;
`endif

        if (init) begin
            // Restart wins over everything, including a pending handshake.
            st_en    = 1'b1;
            st_clear = 1'b1;
            state_d  = ST_IDLE;
            rnd_d    = '0;
`ifdef CHAIN_MIX_BLKCNT_EN
            blk_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_d     = in_data ^ st_q;
                        chain_d = st_q;
                        rnd_d   = '0;
                        state_d = ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    w_d   = w_round;
                    rnd_d = rnd_q + 1'b1;
                    if (rnd_q == ROUND_LAST) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    out_valid = 1'b1;
                    out_data  = w_final;
                    if (out_ready) begin
                        st_en   = 1'b1;
                        st_d    = w_final;
                        state_d = ST_IDLE;
`ifdef CHAIN_MIX_BLKCNT_EN
                        blk_d   = blk_q + 32'd1;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A reset cycle must never write the downstream chaining register.
        if (reset) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_data  = '0;
            st_en     = 1'b0;
            st_clear  = 1'b0;
            st_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            chain_q <= '0;
            rnd_q   <= '0;
`ifdef CHAIN_MIX_BLKCNT_EN
            blk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            chain_q <= chain_d;
            rnd_q   <= rnd_d;
`ifdef CHAIN_MIX_BLKCNT_EN
            blk_q   <= blk_d;
`endif
        end
    end

endmodule

`default_nettype wire
